// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage of a 16-bit word-addressed pipeline. Holds the PC,
// drives the instruction memory address, and loads the IF/ID pipeline
// register. It supports hazard stalls and branch redirects. A halt opcode
// stops fetching until the halt retires downstream.
//
// Parameters
//   RESET_PC  PC loaded on reset
//   NOP       bubble word written to if_id_instr
//   HLT_OPC   opcode (instr[15:12]) of the halt instruction
//
// Ports
//   clk           single clock, rising edge
//   rst           asynchronous, active-high reset
//   stall         hazard stall: hold PC and IF/ID
//   branch_taken  redirect request from a later stage
//   branch_tgt    redirect word address
//   halt_commit   halt instruction retired downstream
//   instr         instruction memory word for the current iaddr
//   iaddr         instruction memory word address (the PC register)
//   rd_en         instruction memory read enable
//   if_id_instr   IF/ID instruction register
//   if_id_pc_inc  IF/ID PC+1 of the captured instruction
//   if_id_valid   IF/ID holds a real instruction
//   halted        processor halted
//   fetch_cnt     count of valid instructions loaded into IF/ID
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP      = 16'h0000,
    parameter logic [3:0]  HLT_OPC  = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_tgt,
    input  logic        halt_commit,
    input  logic [15:0] instr,
    output logic [15:0] iaddr,
    output logic        rd_en,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_inc,
    output logic        if_id_valid,
    output logic        halted,
    output logic [15:0] fetch_cnt
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_inc_q, pc_inc_d;
    logic        valid_q, valid_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] pc_plus1;

    // 16-bit add; the carry out is dropped, so FFFF+1 wraps to 0000.
    assign pc_plus1 = pc_q + 16'd1;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            instr_q  <= NOP;
            pc_inc_q <= 16'h0000;
            valid_q  <= 1'b0;
            cnt_q    <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_inc_q <= pc_inc_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Priority: branch_taken > stall > normal fetch.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every target gets a hold default first. Any path that does not
        // assign a target then keeps the register value instead of
        // inferring a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_inc_d = pc_inc_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            RUN, HALT_PEND: begin
                if (branch_taken) begin
                    // Redirect squashes the IF/ID contents and overrides stall.
                    // A halt in flight is also cancelled.
                    state_d  = RUN;
                    pc_d     = branch_tgt;
                    instr_d  = NOP;
                    pc_inc_d = 16'h0000;
                    valid_d  = 1'b0;
                end else if (!stall) begin
                    if (state_q == RUN) begin
                        instr_d  = instr;
                        pc_inc_d = pc_plus1;
                        valid_d  = 1'b1;
                        cnt_d    = cnt_q + 16'd1;
                        if (instr[15:12] == HLT_OPC) begin
                            // PC parks on the halt; fetching stops until the
                            // halt retires or a branch pulls us back.
                            state_d = HALT_PEND;
                        end else begin
                            pc_d = pc_plus1;
                        end
                    end else begin
                        instr_d  = NOP;
                        pc_inc_d = 16'h0000;
                        valid_d  = 1'b0;
                        if (halt_commit) begin
                            state_d = HALTED;
                        end
                    end
                end
            end
            HALTED: begin
                // Hold everything; only rst leaves this state.
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign iaddr        = pc_q;
    assign rd_en        = (state_q == RUN);
    assign halted       = (state_q == HALTED);
    assign if_id_instr  = instr_q;
    assign if_id_pc_inc = pc_inc_q;
    assign if_id_valid  = valid_q;
    assign fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed-vector bench for instr_fetch. A behavioural instruction memory
// answers combinationally from iaddr. The expected values are hand-computed
// from the memory image loaded below.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_tgt;
    logic        halt_commit;
    logic [15:0] instr;
    logic [15:0] iaddr;
    logic        rd_en;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_inc;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] fetch_cnt;

    logic [15:0] mem [0:65535];

    int n_vec;
    int n_err;

    instr_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_tgt   (branch_tgt),
        .halt_commit  (halt_commit),
        .instr        (instr),
        .iaddr        (iaddr),
        .rd_en        (rd_en),
        .if_id_instr  (if_id_instr),
        .if_id_pc_inc (if_id_pc_inc),
        .if_id_valid  (if_id_valid),
        .halted       (halted),
        .fetch_cnt    (fetch_cnt)
    );

    assign instr = mem[iaddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; outputs are stable there.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst          = 1'b1;
        stall        = 1'b0;
        branch_taken = 1'b0;
        branch_tgt   = 16'h0000;
        halt_commit  = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h1111;
        mem[16'h0001] = 16'h2222;
        mem[16'h0002] = 16'h3333;
        mem[16'h0003] = 16'h4444;
        mem[16'h0004] = 16'h5555;
        mem[16'h0005] = 16'hF000;
        mem[16'h0010] = 16'h1010;
        mem[16'h0040] = 16'h4040;
        mem[16'h0041] = 16'hF000;
        mem[16'hFFFF] = 16'hABCD;

        // Reset state
        tick;
        check("rst_iaddr",  iaddr,        16'h0000);
        check("rst_rd_en",  rd_en,        16'h1);
        check("rst_valid",  if_id_valid,  16'h0);
        check("rst_instr",  if_id_instr,  16'h0000);
        check("rst_pcinc",  if_id_pc_inc, 16'h0000);
        check("rst_halted", halted,       16'h0);
        check("rst_cnt",    fetch_cnt,    16'h0000);
        rst = 1'b0;

        // Sequential fetch
        tick;
        check("seq1_instr", if_id_instr,  16'h1111);
        check("seq1_pcinc", if_id_pc_inc, 16'h0001);
        check("seq1_valid", if_id_valid,  16'h1);
        tick;
        check("seq2_instr", if_id_instr,  16'h2222);
        check("seq2_pcinc", if_id_pc_inc, 16'h0002);
        check("seq2_iaddr", iaddr,        16'h0002);

        // Stall two cycles at iaddr=2
        stall = 1'b1;
        tick;
        tick;
        stall = 1'b0;
        check("stl_iaddr", iaddr,        16'h0002);
        check("stl_instr", if_id_instr,  16'h2222);
        check("stl_pcinc", if_id_pc_inc, 16'h0002);
        check("stl_cnt",   fetch_cnt,    16'h0002);
        tick;
        check("res_instr", if_id_instr,  16'h3333);
        check("res_pcinc", if_id_pc_inc, 16'h0003);
        check("res_cnt",   fetch_cnt,    16'h0003);
        tick;
        tick;
        check("pre_halt_iaddr", iaddr,     16'h0005);
        check("pre_halt_cnt",   fetch_cnt, 16'h0005);

        // Halt at address 5
        tick;
        check("hlt_instr", if_id_instr,  16'hF000);
        check("hlt_pcinc", if_id_pc_inc, 16'h0006);
        check("hlt_valid", if_id_valid,  16'h1);
        check("hlt_iaddr", iaddr,        16'h0005);
        check("hlt_rd_en", rd_en,        16'h0);
        check("hlt_cnt",   fetch_cnt,    16'h0006);
        tick;
        check("hp_valid",  if_id_valid,  16'h0);
        check("hp_instr",  if_id_instr,  16'h0000);
        check("hp_iaddr",  iaddr,        16'h0005);
        check("hp_halted", halted,       16'h0);
        halt_commit = 1'b1;
        tick;
        halt_commit = 1'b0;
        check("hd_halted", halted, 16'h1);
        check("hd_rd_en",  rd_en,  16'h0);
        branch_taken = 1'b1;
        branch_tgt   = 16'h0040;
        stall        = 1'b1;
        tick;
        branch_taken = 1'b0;
        stall        = 1'b0;
        check("hd_br_iaddr",  iaddr,     16'h0005);
        check("hd_br_halted", halted,    16'h1);
        check("hd_br_cnt",    fetch_cnt, 16'h0006);

        // Reset out of HALTED, between edges
        #3;
        rst = 1'b1;
        #1;
        check("rst2_iaddr",  iaddr,  16'h0000);
        check("rst2_halted", halted, 16'h0);
        #2;
        rst = 1'b0;

        // Branch and stall on the same edge
        branch_taken = 1'b1;
        branch_tgt   = 16'h0040;
        stall        = 1'b1;
        tick;
        branch_taken = 1'b0;
        stall        = 1'b0;
        check("bs_iaddr", iaddr,        16'h0040);
        check("bs_valid", if_id_valid,  16'h0);
        check("bs_instr", if_id_instr,  16'h0000);
        check("bs_pcinc", if_id_pc_inc, 16'h0000);
        check("bs_cnt",   fetch_cnt,    16'h0000);
        tick;
        check("bt_instr", if_id_instr,  16'h4040);
        check("bt_pcinc", if_id_pc_inc, 16'h0041);
        check("bt_cnt",   fetch_cnt,    16'h0001);

        // Halt shadowed by a branch on the commit edge
        tick;
        check("sh_rd_en", rd_en,     16'h0);
        check("sh_iaddr", iaddr,     16'h0041);
        check("sh_cnt",   fetch_cnt, 16'h0002);
        branch_taken = 1'b1;
        branch_tgt   = 16'h0010;
        halt_commit  = 1'b1;
        tick;
        branch_taken = 1'b0;
        halt_commit  = 1'b0;
        check("sh_br_rd_en",  rd_en,       16'h1);
        check("sh_br_halted", halted,      16'h0);
        check("sh_br_iaddr",  iaddr,       16'h0010);
        check("sh_br_valid",  if_id_valid, 16'h0);
        tick;
        check("sh_fx_instr", if_id_instr, 16'h1010);
        check("sh_fx_cnt",   fetch_cnt,   16'h0003);

        // Async reset while in HALT_PEND
        branch_taken = 1'b1;
        branch_tgt   = 16'h0005;
        tick;
        branch_taken = 1'b0;
        tick;
        check("ar_pre_rd_en", rd_en,     16'h0);
        check("ar_pre_cnt",   fetch_cnt, 16'h0004);
        #3;
        rst = 1'b1;
        #1;
        check("ar_iaddr",  iaddr,        16'h0000);
        check("ar_rd_en",  rd_en,        16'h1);
        check("ar_valid",  if_id_valid,  16'h0);
        check("ar_instr",  if_id_instr,  16'h0000);
        check("ar_pcinc",  if_id_pc_inc, 16'h0000);
        check("ar_cnt",    fetch_cnt,    16'h0000);
        check("ar_halted", halted,       16'h0);
        #2;
        rst = 1'b0;
        tick;
        check("ar_first_instr", if_id_instr,  16'h1111);
        check("ar_first_pcinc", if_id_pc_inc, 16'h0001);
        check("ar_first_cnt",   fetch_cnt,    16'h0001);

        // PC wrap from FFFF
        branch_taken = 1'b1;
        branch_tgt   = 16'hFFFF;
        tick;
        branch_taken = 1'b0;
        check("wr_iaddr0", iaddr, 16'hFFFF);
        tick;
        check("wr_iaddr", iaddr,        16'h0000);
        check("wr_instr", if_id_instr,  16'hABCD);
        check("wr_pcinc", if_id_pc_inc, 16'h0000);
        check("wr_valid", if_id_valid,  16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
